// File: rtl/prbs_burst_ctrl_pkg.sv
// Shared types and constants for the PRBS burst controller: FSM states,
// LFSR width, default seed and the X^4 + X^3 + 1 tap positions.
package prbs_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 4'b0001;
  localparam int TAP_A = 3;
  localparam int TAP_B = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction

endpackage

// File: rtl/prbs_burst_ctrl_if.sv
// Command and output-stream bundle of the PRBS burst controller.
// Optional macro PRBS_BURST_CONT_EN adds cmd_cont (continue LFSR across bursts).
interface prbs_burst_ctrl_if #(
  parameter int LEN_W = 8
);
  import prbs_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LFSR_W-1:0] cmd_seed;
  logic [LEN_W-1:0]  cmd_len;
`ifdef PRBS_BURST_CONT_EN
  logic              cmd_cont;
`endif
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [LFSR_W-1:0] out_data;
  logic              out_last;

  modport master (
`ifdef PRBS_BURST_CONT_EN
    output cmd_cont,
`endif
    output cmd_valid, cmd_seed, cmd_len, abort, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
`ifdef PRBS_BURST_CONT_EN
    input  cmd_cont,
`endif
    input  cmd_valid, cmd_seed, cmd_len, abort, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/prbs_burst_ctrl_lfsr.sv
// 4-bit Fibonacci LFSR (X^4 + X^3 + 1); load has priority over step.
module lfsr4_core
  import prbs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Command-driven burst sequencer streaming LFSR nibbles over valid/ready.
// Optional macro PRBS_BURST_CONT_EN: cmd_cont keeps LFSR state across bursts.
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  prbs_burst_ctrl_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               err_seed
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              done_q, done_d;
  logic              err_seed_q, err_seed_d;
  logic              lfsr_load, lfsr_step, cont;
  logic [LFSR_W-1:0] lfsr_state, load_val;
  logic              accept, last;

`ifdef PRBS_BURST_CONT_EN
  assign cont = bus.cmd_cont;
`else
  assign cont = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && bus.cmd_valid;
  assign last     = (remaining_q == LEN_W'(1));
  assign load_val = (bus.cmd_seed == '0) ? SEED_DEFAULT : bus.cmd_seed;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_seed_d  = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          remaining_d = bus.cmd_len;
          lfsr_load   = !cont;
          err_seed_d  = !cont && (bus.cmd_seed == '0);
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Abort wins over a same-cycle handshake: the beat is not consumed.
        if (bus.abort) begin
          state_d     = IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
        end else if (bus.out_ready) begin
          lfsr_step   = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
      err_seed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      err_seed_q  <= err_seed_d;
    end
  end

  lfsr4_core u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == RUN);
  assign bus.out_data  = lfsr_state;
  assign bus.out_last  = (state_q == RUN) && last;
  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign err_seed      = err_seed_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed bench for prbs_burst_ctrl: bursts, stalls, zero seed/len, wrap, abort, reset.
module tb_prbs_burst_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, err_seed;
  int   checks = 0;
  int   errors = 0;

  prbs_burst_ctrl_if #(.LEN_W(8)) bus ();

  prbs_burst_ctrl #(.LEN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err_seed (err_seed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] seed, input logic [7:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_seed  = seed;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Sequence from seed 1: 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8, then wraps to 1.
  logic [3:0] seq16 [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_seed  = 4'h0;
    bus.cmd_len   = 8'd0;
`ifdef PRBS_BURST_CONT_EN
    bus.cmd_cont  = 1'b0;
`endif
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 4'h1);
    chk("rst_out_last",  bus.out_last, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_done",      done, 0);
    chk("rst_err_seed",  err_seed, 0);
    rst = 1'b0;
    tick();

    // Burst 1: seed 1, len 4, consumer always ready.
    bus.out_ready = 1'b1;
    send(4'h1, 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk("b1_valid", bus.out_valid, 1);
      chk("b1_data",  bus.out_data, seq16[i]);
      chk("b1_last",  bus.out_last, (i == 3) ? 1 : 0);
      chk("b1_busy",  busy, 1);
      chk("b1_done",  done, 0);
      tick();
    end
    chk("b1_done_pulse", done, 1);
    chk("b1_valid_off",  bus.out_valid, 0);
    chk("b1_cmd_ready",  bus.cmd_ready, 1);
    tick();
    chk("b1_done_one_cycle", done, 0);

    // Burst 2: same command with a stall before every beat.
    bus.out_ready = 1'b0;
    send(4'h1, 8'd4);
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = 1'b0;
      chk("b2_data",  bus.out_data, seq16[i]);
      tick();
      chk("b2_stall_valid", bus.out_valid, 1);
      chk("b2_stall_data",  bus.out_data, seq16[i]);
      chk("b2_stall_last",  bus.out_last, (i == 3) ? 1 : 0);
      bus.out_ready = 1'b1;
      tick();
    end
    chk("b2_done_pulse", done, 1);
    chk("b2_valid_off",  bus.out_valid, 0);
    tick();

    // Zero seed is replaced by 1 and flagged.
    send(4'h0, 8'd2);
    chk("z_err_seed", err_seed, 1);
    chk("z_data0",    bus.out_data, 4'h1);
    chk("z_last0",    bus.out_last, 0);
    tick();
    chk("z_err_one_cycle", err_seed, 0);
    chk("z_data1",    bus.out_data, 4'h2);
    chk("z_last1",    bus.out_last, 1);
    tick();
    chk("z_done", done, 1);
    tick();

    // Empty burst: done only, LFSR still reloaded.
    send(4'h5, 8'd0);
    chk("e_done",      done, 1);
    chk("e_valid",     bus.out_valid, 0);
    chk("e_cmd_ready", bus.cmd_ready, 1);
    chk("e_err_seed",  err_seed, 0);
    chk("e_data",      bus.out_data, 4'h5);
    tick();
    chk("e_done_off",  done, 0);
    chk("e_valid_off", bus.out_valid, 0);

    // Length 16 wraps past the 15-state period.
    send(4'h1, 8'd16);
    for (int i = 0; i < 16; i++) begin
      chk("w_data", bus.out_data, seq16[i]);
      chk("w_last", bus.out_last, (i == 15) ? 1 : 0);
      tick();
    end
    chk("w_done", done, 1);
    tick();

    // Abort during the third beat: handshake in the same cycle is dropped.
    send(4'h1, 8'd10);
    tick();
    tick();
    chk("a_data3", bus.out_data, 4'h4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("a_valid_off", bus.out_valid, 0);
    chk("a_done",      done, 1);
    chk("a_busy",      busy, 0);
    chk("a_lfsr_held", bus.out_data, 4'h4);
    tick();
    chk("a_done_off", done, 0);

    // Abort in IDLE does not block a same-cycle accept.
    bus.abort = 1'b1;
    send(4'h3, 8'd1);
    bus.abort = 1'b0;
    chk("ia_valid", bus.out_valid, 1);
    chk("ia_data",  bus.out_data, 4'h3);
    chk("ia_last",  bus.out_last, 1);
    tick();
    chk("ia_done", done, 1);
    tick();

    // Reset mid-burst discards it without a done pulse.
    send(4'h1, 8'd5);
    tick();
    chk("r_data_pre", bus.out_data, 4'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_valid",     bus.out_valid, 0);
    chk("r_data",      bus.out_data, 4'h1);
    chk("r_last",      bus.out_last, 0);
    chk("r_done",      done, 0);
    chk("r_busy",      busy, 0);
    chk("r_err_seed",  err_seed, 0);
    chk("r_cmd_ready", bus.cmd_ready, 1);
    tick();
    chk("r_done_after", done, 0);
    send(4'h8, 8'd2);
    chk("r2_data0", bus.out_data, 4'h8);
    chk("r2_last0", bus.out_last, 0);
    tick();
    chk("r2_data1", bus.out_data, 4'h1);
    chk("r2_last1", bus.out_last, 1);
    tick();
    chk("r2_done", done, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
